// File: rtl/audio_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module : audio_ctrl_seq
// Sequences volume, mute, filter and mix controls for audio_mixer so that
// filter/mix changes only ever land while the output is muted.
// Rev    : 1.0
// ============================================================================
module audio_ctrl_seq #(
  parameter int TICK_DIV   = 2048,
  parameter int SETTLE_CYC = 4096,
  parameter int ATT_MIN    = 15
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [3:0] req_vol,
  input  logic [3:0] req_filter,
  input  logic [1:0] req_mix,
  input  logic       req_pause,
  output logic [3:0] vol_att,
  output logic       mute,
  output logic [3:0] afilter_sw,
  output logic [1:0] mix,
  output logic       busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYC - 1);
  localparam logic [3:0]    ATT_SIL     = 4'(ATT_MIN);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_OUT = 3'd1,
    APPLY    = 3'd2,
    PAUSED   = 3'd3,
    SETTLE   = 3'd4,
    FADE_IN  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    vol_q, vol_d;
  logic          mute_q, mute_d;
  logic [3:0]    filt_q, filt_d;
  logic [1:0]    mix_q, mix_d;
  logic          busy_q, busy_d;

  logic       tick;
  logic       diff;
  logic       change;
  logic [3:0] vol_step;

  assign tick   = (tick_q == TICK_LAST);
  assign diff   = (req_filter != filt_q) || (req_mix != mix_q);
  assign change = req_pause || diff;

  always_comb begin
    if (vol_q < req_vol)      vol_step = vol_q + 4'd1;
    else if (vol_q > req_vol) vol_step = vol_q - 4'd1;
    else                      vol_step = vol_q;
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    vol_d    = vol_q;
    mute_d   = mute_q;
    filt_d   = filt_q;
    mix_d    = mix_q;
    case (state_q)
      IDLE: begin
        mute_d = 1'b0;
        if (change)    state_d = FADE_OUT;
        else if (tick) vol_d   = vol_step;
      end
      FADE_OUT: begin
        if (vol_q == ATT_SIL) begin
          mute_d  = 1'b1;
          state_d = APPLY;
        end else if (tick) begin
          vol_d = vol_q + 4'd1;
        end
      end
      APPLY: begin
        filt_d   = req_filter;
        mix_d    = req_mix;
        settle_d = SETTLE_INIT;
        state_d  = req_pause ? PAUSED : SETTLE;
      end
      PAUSED: begin
        mute_d = 1'b1;
        vol_d  = ATT_SIL;
        if (!req_pause) state_d = APPLY;
      end
      SETTLE: begin
        if (change) begin
          state_d = APPLY;
        end else if (settle_q == '0) begin
          mute_d  = 1'b0;
          state_d = FADE_IN;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      FADE_IN: begin
        // Aborting a fade-in reverses from the current level, no jump to silence
        if (change)                state_d = FADE_OUT;
        else if (vol_q == req_vol) state_d = IDLE;
        else if (tick)             vol_d   = vol_step;
      end
      default: state_d = SETTLE;
    endcase

    // Restarting the divider on entry makes the first step a full period away
    if (state_d != state_q) tick_d = '0;
    else if (tick)          tick_d = '0;
    else                    tick_d = tick_q + 1'b1;

    busy_d = (state_d != IDLE) || (vol_d != req_vol);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= SETTLE;
      tick_q   <= '0;
      settle_q <= SETTLE_INIT;
      vol_q    <= ATT_SIL;
      mute_q   <= 1'b1;
      filt_q   <= 4'd0;
      mix_q    <= 2'd0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      settle_q <= settle_d;
      vol_q    <= vol_d;
      mute_q   <= mute_d;
      filt_q   <= filt_d;
      mix_q    <= mix_d;
      busy_q   <= busy_d;
    end
  end

  assign vol_att    = vol_q;
  assign mute       = mute_q;
  assign afilter_sw = filt_q;
  assign mix        = mix_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_audio_ctrl_seq
// Scenario bench for audio_ctrl_seq; every output change is matched against a
// queue of expected {vol_att, mute, afilter_sw, mix} values.
// Rev    : 1.0
// ============================================================================
module tb_audio_ctrl_seq;

  localparam int TICK_DIV   = 4;
  localparam int SETTLE_CYC = 8;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] req_vol    = 4'd0;
  logic [3:0] req_filter = 4'd0;
  logic [1:0] req_mix    = 2'd0;
  logic       req_pause  = 1'b0;
  logic [3:0] vol_att;
  logic       mute;
  logic [3:0] afilter_sw;
  logic [1:0] mix;
  logic       busy;

  typedef struct packed {
    logic [3:0] vol;
    logic       mute;
    logic [3:0] filt;
    logic [1:0] mix;
  } out_t;

  out_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  out_t prev;

  audio_ctrl_seq #(.TICK_DIV(TICK_DIV), .SETTLE_CYC(SETTLE_CYC), .ATT_MIN(15)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req_vol   (req_vol),
    .req_filter(req_filter),
    .req_mix   (req_mix),
    .req_pause (req_pause),
    .vol_att   (vol_att),
    .mute      (mute),
    .afilter_sw(afilter_sw),
    .mix       (mix),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Output-change monitor: each new output combination must be the next queued one
  always @(negedge clk_sys) begin
    out_t cur;
    out_t exp;
    cur = '{vol: vol_att, mute: mute, filt: afilter_sw, mix: mix};
    if (mon_en && cur !== prev) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got vol=%0d mute=%0d filt=%0d mix=%0d, required no change",
                 cur.vol, cur.mute, cur.filt, cur.mix);
      end else begin
        exp = sb_q.pop_front();
        if (cur !== exp) begin
          errors++;
          $display("FAIL out_seq: got vol=%0d mute=%0d filt=%0d mix=%0d, required vol=%0d mute=%0d filt=%0d mix=%0d",
                   cur.vol, cur.mute, cur.filt, cur.mix, exp.vol, exp.mute, exp.filt, exp.mix);
        end
      end
    end
    prev = cur;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input int v, input logic m, input logic [3:0] f, input logic [1:0] x);
    sb_q.push_back('{vol: 4'(v), mute: m, filt: f, mix: x});
  endtask

  // Queue every level strictly after 'from' up to and including 'to'
  task automatic push_ramp(input int from, input int to, input logic m,
                           input logic [3:0] f, input logic [1:0] x);
    int v = from;
    while (v != to) begin
      v = (v < to) ? v + 1 : v - 1;
      push(v, m, f, x);
    end
  endtask

  // sel: 0 vol_att, 1 afilter_sw, 2 mute, 3 mix
  task automatic wait_sig(input int sel, input int value, input int budget, output bit ok);
    int cur;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      case (sel)
        0:       cur = int'(vol_att);
        1:       cur = int'(afilter_sw);
        2:       cur = int'(mute);
        default: cur = int'(mix);
      endcase
      if (cur == value) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic test_reset;
    bit ok;
    reset = 1'b1;
    cyc(3);
    checks++;
    if ({vol_att, mute, afilter_sw, mix, busy} !== {4'd15, 1'b1, 4'd0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_vals: got vol=%0d mute=%0d filt=%0d mix=%0d busy=%0d, required 15 1 0 0 1",
               vol_att, mute, afilter_sw, mix, busy);
    end
    mon_en = 1'b1;
    push(15, 1'b0, 4'd0, 2'd0);
    push_ramp(15, 0, 1'b0, 4'd0, 2'd0);
    reset = 1'b0;
    cyc(7);
    checks++;
    if (mute !== 1'b1 || vol_att !== 4'd15) begin
      errors++;
      $display("FAIL settle_hold: got mute=%0d vol=%0d, required mute=1 vol=15", mute, vol_att);
    end
    cyc(1);
    checks++;
    if (mute !== 1'b0) begin
      errors++;
      $display("FAIL settle_release: got mute=%0d, required 0", mute);
    end
    cyc(3);
    checks++;
    if (vol_att !== 4'd15) begin
      errors++;
      $display("FAIL first_step_early: got vol=%0d, required 15", vol_att);
    end
    cyc(1);
    checks++;
    if (vol_att !== 4'd14) begin
      errors++;
      $display("FAIL first_step: got vol=%0d, required 14", vol_att);
    end
    cyc(56);
    checks++;
    if (vol_att !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fade_in_end: got vol=%0d busy=%0d, required vol=0 busy=1", vol_att, busy);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: got busy=%0d, required 0", busy);
    end
    wait_drain(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_vol_ramp;
    bit ok;
    req_vol = 4'd3;
    push_ramp(0, 3, 1'b0, 4'd0, 2'd0);
    cyc(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL vol_busy: got busy=%0d, required 1", busy);
    end
    wait_sig(0, 1, 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL vol_step1_timeout: got vol=%0d, required 1", vol_att);
    end
    cyc(3);
    checks++;
    if (vol_att !== 4'd1) begin
      errors++;
      $display("FAIL vol_interval_early: got vol=%0d, required 1", vol_att);
    end
    cyc(1);
    checks++;
    if (vol_att !== 4'd2) begin
      errors++;
      $display("FAIL vol_interval: got vol=%0d, required 2", vol_att);
    end
    cyc(4);
    checks++;
    if (vol_att !== 4'd3 || busy !== 1'b0 || mute !== 1'b0) begin
      errors++;
      $display("FAIL vol_done: got vol=%0d busy=%0d mute=%0d, required 3 0 0", vol_att, busy, mute);
    end
    wait_drain(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL vol_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_filter_change;
    bit ok;
    req_vol = 4'd2;
    push(2, 1'b0, 4'd0, 2'd0);
    wait_sig(0, 2, 20, ok);
    req_filter = 4'd5;
    push_ramp(2, 15, 1'b0, 4'd0, 2'd0);
    push(15, 1'b1, 4'd0, 2'd0);
    push(15, 1'b1, 4'd5, 2'd0);
    push(15, 1'b0, 4'd5, 2'd0);
    push_ramp(15, 2, 1'b0, 4'd5, 2'd0);
    wait_sig(1, 5, 100, ok);
    checks++;
    if (!ok || mute !== 1'b1) begin
      errors++;
      $display("FAIL filt_apply: got filt=%0d mute=%0d, required filt=5 mute=1", afilter_sw, mute);
    end
    cyc(7);
    checks++;
    if (mute !== 1'b1) begin
      errors++;
      $display("FAIL filt_settle_hold: got mute=%0d, required 1", mute);
    end
    cyc(1);
    checks++;
    if (mute !== 1'b0) begin
      errors++;
      $display("FAIL filt_settle_release: got mute=%0d, required 0", mute);
    end
    wait_sig(0, 2, 100, ok);
    wait_drain(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL filt_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_pause;
    bit ok;
    req_vol = 4'd0;
    push_ramp(2, 0, 1'b0, 4'd5, 2'd0);
    wait_sig(0, 0, 20, ok);
    req_pause = 1'b1;
    push_ramp(0, 15, 1'b0, 4'd5, 2'd0);
    push(15, 1'b1, 4'd5, 2'd0);
    wait_sig(2, 1, 120, ok);
    cyc(40);
    checks++;
    if (!ok || mute !== 1'b1 || vol_att !== 4'd15 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pause_hold: got mute=%0d vol=%0d busy=%0d, required 1 15 1", mute, vol_att, busy);
    end
    req_mix = 2'd2;
    cyc(20);
    checks++;
    if (mix !== 2'd0) begin
      errors++;
      $display("FAIL pause_mix_hold: got mix=%0d, required 0", mix);
    end
    req_pause = 1'b0;
    push(15, 1'b1, 4'd5, 2'd2);
    push(15, 1'b0, 4'd5, 2'd2);
    push_ramp(15, 0, 1'b0, 4'd5, 2'd2);
    wait_sig(3, 2, 10, ok);
    checks++;
    if (!ok || mute !== 1'b1) begin
      errors++;
      $display("FAIL unpause_apply: got mix=%0d mute=%0d, required mix=2 mute=1", mix, mute);
    end
    wait_sig(0, 0, 150, ok);
    wait_drain(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pause_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_settle_restart;
    bit ok;
    req_filter = 4'd7;
    push_ramp(0, 15, 1'b0, 4'd5, 2'd2);
    push(15, 1'b1, 4'd5, 2'd2);
    push(15, 1'b1, 4'd7, 2'd2);
    wait_sig(1, 7, 120, ok);
    cyc(4);
    req_filter = 4'd9;
    push(15, 1'b1, 4'd9, 2'd2);
    push(15, 1'b0, 4'd9, 2'd2);
    push_ramp(15, 0, 1'b0, 4'd9, 2'd2);
    cyc(2);
    checks++;
    if (afilter_sw !== 4'd9 || mute !== 1'b1) begin
      errors++;
      $display("FAIL reapply: got filt=%0d mute=%0d, required filt=9 mute=1", afilter_sw, mute);
    end
    cyc(7);
    checks++;
    if (mute !== 1'b1) begin
      errors++;
      $display("FAIL restart_hold: got mute=%0d, required 1", mute);
    end
    cyc(1);
    checks++;
    if (mute !== 1'b0) begin
      errors++;
      $display("FAIL restart_release: got mute=%0d, required 0", mute);
    end
    wait_sig(0, 0, 100, ok);
    wait_drain(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_fade;
    bit ok;
    req_mix = 2'd1;
    push_ramp(0, 15, 1'b0, 4'd9, 2'd2);
    push(15, 1'b1, 4'd9, 2'd2);
    push(15, 1'b1, 4'd9, 2'd1);
    push(15, 1'b0, 4'd9, 2'd1);
    push_ramp(15, 9, 1'b0, 4'd9, 2'd1);
    push(15, 1'b1, 4'd0, 2'd0);
    wait_sig(3, 1, 120, ok);
    wait_sig(0, 9, 60, ok);
    reset = 1'b1;
    cyc(1);
    checks++;
    if (!ok || {vol_att, mute, afilter_sw, mix, busy} !== {4'd15, 1'b1, 4'd0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_vals: got vol=%0d mute=%0d filt=%0d mix=%0d busy=%0d, required 15 1 0 0 1",
               vol_att, mute, afilter_sw, mix, busy);
    end
    push(15, 1'b1, 4'd9, 2'd1);
    push(15, 1'b0, 4'd9, 2'd1);
    push_ramp(15, 0, 1'b0, 4'd9, 2'd1);
    reset = 1'b0;
    cyc(2);
    checks++;
    if (afilter_sw !== 4'd9 || mix !== 2'd1 || mute !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_apply: got filt=%0d mix=%0d mute=%0d, required 9 1 1",
               afilter_sw, mix, mute);
    end
    wait_sig(0, 0, 150, ok);
    wait_drain(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vol_ramp();
    test_filter_change();
    test_pause();
    test_settle_restart();
    test_reset_mid_fade();
    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
